// File: rtl/pwl_filter_sched_pkg.sv
// Shared types and default widths for the PWL filter scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwl_sched_pkg;

  localparam int TIME_BITS    = 32;  // absolute timestamp width
  localparam int PWL_PT_BITS  = 16;  // evaluator time_point width
  localparam int PWL_OUT_BITS = 18;  // evaluator signed output width
  localparam int DEF_N_TERMS  = 8;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_LAT      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Travels alongside each issued time point so the returning result knows
  // whether, and with which sign, it contributes to the sum.
  typedef struct packed {
    logic valid;
    logic sign;
  } tag_t;

endpackage

// File: rtl/pwl_filter_sched_if.sv
// Bundles the event-push, evaluation-control and evaluator-link signals.
// Latency: n/a (wiring only). sat_flag exists only with PWL_SCHED_SAT_EN.
// Backpressure: ev_ready gates ev_valid; start is ignored while busy.
interface pwl_filter_sched_if #(
  parameter int N_TERMS = pwl_sched_pkg::DEF_N_TERMS,
  parameter int TIME_W  = pwl_sched_pkg::TIME_BITS,
  parameter int PT_W    = pwl_sched_pkg::PWL_PT_BITS,
  parameter int OUT_W   = pwl_sched_pkg::PWL_OUT_BITS,
  parameter int ACC_W   = pwl_sched_pkg::DEF_ACC_W
);
  localparam int CNT_W = $clog2(N_TERMS) + 1;

  logic                     ev_valid;
  logic                     ev_ready;
  logic [TIME_W-1:0]        ev_time;
  logic                     ev_pol;
  logic                     ev_drop;
  logic                     start;
  logic [TIME_W-1:0]        time_now;
  logic                     busy;
  logic [PT_W-1:0]          pwl_time_point;
  logic signed [OUT_W-1:0]  pwl_out;
  logic signed [ACC_W-1:0]  sum_out;
  logic                     done;
  logic [CNT_W-1:0]         hist_count;
`ifdef PWL_SCHED_SAT_EN
  logic                     sat_flag;

  modport master (
    output ev_valid, ev_time, ev_pol, start, time_now, pwl_out,
    input  ev_ready, ev_drop, busy, pwl_time_point, sum_out, done, hist_count, sat_flag
  );
  modport slave (
    input  ev_valid, ev_time, ev_pol, start, time_now, pwl_out,
    output ev_ready, ev_drop, busy, pwl_time_point, sum_out, done, hist_count, sat_flag
  );
`else
  modport master (
    output ev_valid, ev_time, ev_pol, start, time_now, pwl_out,
    input  ev_ready, ev_drop, busy, pwl_time_point, sum_out, done, hist_count
  );
  modport slave (
    input  ev_valid, ev_time, ev_pol, start, time_now, pwl_out,
    output ev_ready, ev_drop, busy, pwl_time_point, sum_out, done, hist_count
  );
`endif

endinterface

// File: rtl/pwl_event_hist.sv
// Event history shift register, newest at index 0, with push/drop/truncate.
// Latency: push visible next cycle; drop pulses the cycle after a full push.
// Backpressure: none; a push while full silently evicts the oldest entry.
module pwl_event_hist #(
  parameter  int N_TERMS = 8,
  parameter  int TIME_W  = 32,
  localparam int IDX_W   = $clog2(N_TERMS),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [TIME_W-1:0] push_time,
  input  logic              push_pol,
  input  logic              trunc_en,
  input  logic [CNT_W-1:0]  trunc_cnt,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TIME_W-1:0] rd_time,
  output logic              rd_pol,
  output logic [CNT_W-1:0]  count,
  output logic              drop
);

  logic [TIME_W-1:0]  time_q [N_TERMS];
  logic [N_TERMS-1:0] pol_q;
  logic [N_TERMS-1:0] vld_q;

  // Shift in on push; otherwise invalidate everything at or beyond trunc_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      pol_q <= '0;
      drop  <= 1'b0;
      for (int i = 0; i < N_TERMS; i++) time_q[i] <= '0;
    end else begin
      drop <= push && vld_q[N_TERMS-1];
      if (push) begin
        time_q[0] <= push_time;
        for (int i = 1; i < N_TERMS; i++) time_q[i] <= time_q[i-1];
        pol_q <= {pol_q[N_TERMS-2:0], push_pol};
        vld_q <= {vld_q[N_TERMS-2:0], 1'b1};
      end else if (trunc_en) begin
        for (int i = 0; i < N_TERMS; i++) begin
          if (CNT_W'(i) >= trunc_cnt) vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Valid entries are always contiguous from index 0, so the count is a popcount.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_TERMS; i++) count = count + CNT_W'(vld_q[i]);
  end

  assign rd_time = time_q[rd_idx];
  assign rd_pol  = pol_q[rd_idx];

endmodule

// File: rtl/pwl_filter_sched.sv
// Time-multiplexes one PWL evaluator over the stored event history and sums the signed results.
// Latency: done arrives 1+k+LAT cycles after start (k = issued entries). Optional macro: PWL_SCHED_SAT_EN.
// Backpressure: ev_ready low and start ignored while busy; evaluator is never stalled.
module pwl_filter_sched
  import pwl_sched_pkg::*;
#(
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int TIME_W  = TIME_BITS,
  parameter int PT_W    = PWL_PT_BITS,
  parameter int OUT_W   = PWL_OUT_BITS,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LAT     = DEF_LAT
) (
  input logic clk_sys,
  input logic rst,
  pwl_filter_sched_if.slave bus
);

  localparam int IDX_W = $clog2(N_TERMS);
  localparam int CNT_W = IDX_W + 1;
  localparam int DR_W  = $clog2(LAT) + 1;

  state_t                  state;
  logic [TIME_W-1:0]       tnow_q;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        n_issue;
  logic [DR_W-1:0]         drain_cnt;
  logic                    trunc_vld;
  logic [CNT_W-1:0]        trunc_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] ext;
  tag_t                    tag_pipe [LAT];
  tag_t                    issue_tag;
  tag_t                    ret_tag;

  logic                    push;
  logic                    start_acc;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_eff;
  logic [TIME_W-1:0]       rd_time;
  logic                    rd_pol;
  logic [TIME_W-1:0]       dt;
  logic                    expired;
`ifdef PWL_SCHED_SAT_EN
  logic signed [ACC_W:0]   acc_wide;
  logic                    sat_hit;
`endif

  assign push      = bus.ev_valid && (state == ST_IDLE);
  assign start_acc = bus.start && (state == ST_IDLE);
  // A same-cycle push lands before the evaluation reads the history.
  assign count_eff = !push ? count :
                     (count == CNT_W'(N_TERMS)) ? count : count + CNT_W'(1);
  assign dt        = tnow_q - rd_time;
  assign expired   = |dt[TIME_W-1:PT_W];

  assign bus.ev_ready   = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.hist_count = count;

  pwl_event_hist #(
    .N_TERMS (N_TERMS),
    .TIME_W  (TIME_W)
  ) u_hist (
    .clk       (clk_sys),
    .rst       (rst),
    .push      (push),
    .push_time (bus.ev_time),
    .push_pol  (bus.ev_pol),
    .trunc_en  ((state == ST_DONE) && trunc_vld),
    .trunc_cnt (trunc_idx),
    .rd_idx    (idx),
    .rd_time   (rd_time),
    .rd_pol    (rd_pol),
    .count     (count),
    .drop      (bus.ev_drop)
  );

  // Sequencer: issue one history entry per cycle, drain the evaluator, publish the sum.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state              <= ST_IDLE;
      tnow_q             <= '0;
      idx                <= '0;
      n_issue            <= '0;
      drain_cnt          <= '0;
      trunc_vld          <= 1'b0;
      trunc_idx          <= '0;
      bus.pwl_time_point <= '0;
      bus.sum_out        <= '0;
      bus.done           <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tnow_q    <= bus.time_now;
            idx       <= '0;
            n_issue   <= count_eff;
            drain_cnt <= '0;
            trunc_vld <= 1'b0;
            state     <= (count_eff == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (expired) begin
            // Older entries are even further in the past, so stop here.
            trunc_vld <= 1'b1;
            trunc_idx <= {1'b0, idx};
            state     <= ST_DRAIN;
          end else begin
            bus.pwl_time_point <= dt[PT_W-1:0];
            if ({1'b0, idx} == n_issue - CNT_W'(1)) state <= ST_DRAIN;
            else                                   idx   <= idx + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DR_W'(LAT - 1)) begin
            state       <= ST_DONE;
            bus.done    <= 1'b1;
            bus.sum_out <= acc_next;
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag of the slot issued this cycle; expired slots carry no contribution.
  always_comb begin
    issue_tag.valid = (state == ST_ISSUE) && !expired;
    issue_tag.sign  = rd_pol;
  end

  // Delay tags by LAT so each one meets its evaluator result.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign ret_tag = tag_pipe[LAT-1];

  // Next accumulator value: add or subtract the sign-extended result when its tag is valid.
  always_comb begin
    ext      = ACC_W'(bus.pwl_out);
    acc_next = acc;
`ifdef PWL_SCHED_SAT_EN
    sat_hit  = 1'b0;
    acc_wide = ret_tag.sign ? ({acc[ACC_W-1], acc} + {ext[ACC_W-1], ext})
                            : ({acc[ACC_W-1], acc} - {ext[ACC_W-1], ext});
    if (ret_tag.valid) begin
      if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
        sat_hit  = 1'b1;
        acc_next = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = acc_wide[ACC_W-1:0];
      end
    end
`else
    if (ret_tag.valid) acc_next = ret_tag.sign ? (acc + ext) : (acc - ext);
`endif
  end

  // Accumulator register, cleared when an evaluation is accepted.
  always_ff @(posedge clk_sys) begin
    if (rst)            acc <= '0;
    else if (start_acc) acc <= '0;
    else                acc <= acc_next;
  end

`ifdef PWL_SCHED_SAT_EN
  // Sticky saturation indicator for the current evaluation.
  always_ff @(posedge clk_sys) begin
    if (rst)            bus.sat_flag <= 1'b0;
    else if (start_acc) bus.sat_flag <= 1'b0;
    else if (sat_hit)   bus.sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pwl_filter_sched.sv
// Directed plus randomized bench with a queue-based history model and a stub evaluator.
// Stub evaluator: pwl_out follows pwl_time_point through LAT-1 extra register stages.
module tb_pwl_filter_sched;

  localparam int N_TERMS = 8;
  localparam int TIME_W  = 32;
  localparam int PT_W    = 16;
  localparam int OUT_W   = 18;
  localparam int ACC_W   = 20;
  localparam int LAT     = 2;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
`ifdef PWL_SCHED_SAT_EN
  localparam longint SAT_CASE_EXP = 524287;
`else
  localparam longint SAT_CASE_EXP = -8;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   mode;
  logic [31:0] hq_t [$];
  bit          hq_p [$];
  logic [PT_W-1:0] pt_d;

  pwl_filter_sched_if #(.N_TERMS(N_TERMS), .TIME_W(TIME_W), .PT_W(PT_W),
                        .OUT_W(OUT_W), .ACC_W(ACC_W)) bus ();

  pwl_filter_sched #(.N_TERMS(N_TERMS), .TIME_W(TIME_W), .PT_W(PT_W),
                     .OUT_W(OUT_W), .ACC_W(ACC_W), .LAT(LAT)) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [OUT_W-1:0] stub_f(input logic [PT_W-1:0] dt, input int m);
    case (m)
      0:       return OUT_W'(dt);
      1:       return 18'sd131071;
      default: return OUT_W'((int'(dt) * 7) % 200000 - 100000);
    endcase
  endfunction

  // LAT=2: the registered time point plus one stage here.
  always_ff @(posedge clk) pt_d <= bus.pwl_time_point;
  always_comb bus.pwl_out = stub_f(pt_d, mode);

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint acc_add(input longint a, input longint v, inout bit s);
    longint r;
    r = a + v;
`ifdef PWL_SCHED_SAT_EN
    if (r > ACC_MAX) begin r = ACC_MAX; s = 1'b1; end
    if (r < ACC_MIN) begin r = ACC_MIN; s = 1'b1; end
`else
    r = r & ((64'sd1 <<< ACC_W) - 1);
    if (r > ACC_MAX) r = r - (64'sd1 <<< ACC_W);
`endif
    return r;
  endfunction

  function automatic bit model_push(input logic [31:0] t, input bit p);
    hq_t.push_front(t);
    hq_p.push_front(p);
    if (hq_t.size() > N_TERMS) begin
      void'(hq_t.pop_back());
      void'(hq_p.pop_back());
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hq_t.delete();
    hq_p.delete();
  endtask

  task automatic push_ev(input logic [31:0] t, input bit p);
    bit exp_drop;
    check("ev_ready_idle", bus.ev_ready, 1);
    bus.ev_valid = 1'b1;
    bus.ev_time  = t;
    bus.ev_pol   = p;
    @(posedge clk);
    exp_drop = model_push(t, p);
    @(negedge clk);
    bus.ev_valid = 1'b0;
    check("ev_drop", bus.ev_drop, exp_drop);
  endtask

  task automatic run_eval(input logic [31:0] tnow, input bit with_push, input logic [31:0] pt,
                          input bit pp, input bit poke);
    logic [31:0] exp_pt [$];
    bit          chk_pt [$];
    logic [31:0] dt;
    int          k;
    int          done_c;
    int          trunc_to;
    longint      acc;
    longint      v;
    bit          s;
    bit          exp_drop;
    bus.start    = 1'b1;
    bus.time_now = tnow;
    if (with_push) begin
      bus.ev_valid = 1'b1;
      bus.ev_time  = pt;
      bus.ev_pol   = pp;
    end
    exp_drop = with_push ? model_push(pt, pp) : 1'b0;
    k = 0; acc = 0; s = 1'b0; trunc_to = -1;
    for (int i = 0; i < hq_t.size(); i++) begin
      dt = tnow - hq_t[i];
      k++;
      if (dt >= 32'd65536) begin
        exp_pt.push_back(0); chk_pt.push_back(1'b0);
        trunc_to = i;
        break;
      end
      exp_pt.push_back(dt); chk_pt.push_back(1'b1);
      v   = longint'(stub_f(dt[PT_W-1:0], mode));
      acc = acc_add(acc, hq_p[i] ? v : -v, s);
    end
    if (trunc_to >= 0) begin
      while (hq_t.size() > trunc_to) begin
        void'(hq_t.pop_back());
        void'(hq_p.pop_back());
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.ev_valid = 1'b0;
    if (with_push) check("ev_drop_start", bus.ev_drop, exp_drop);
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      if (poke && c == 1) begin
        bus.start = 1'b1; bus.time_now = 32'h0; bus.ev_valid = 1'b1;
        bus.ev_time = $urandom; bus.ev_pol = 1'b1;
      end
      if (poke && c == 2) begin bus.start = 1'b0; bus.ev_valid = 1'b0; end
      if (c >= 2 && c - 2 < k && chk_pt[c-2]) check("time_point", bus.pwl_time_point, exp_pt[c-2]);
      if (c == 1) begin
        check("busy", bus.busy, 1);
        check("ev_ready_busy", bus.ev_ready, 0);
      end
      if (bus.done === 1'b1) begin done_c = c; break; end
      @(negedge clk);
    end
    check("done_latency", done_c, 1 + k + LAT);
    check("sum_out", bus.sum_out, acc);
`ifdef PWL_SCHED_SAT_EN
    check("sat_flag", bus.sat_flag, s);
`endif
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    check("sum_hold", bus.sum_out, acc);
    check("idle_after", bus.busy, 0);
    check("hist_count", bus.hist_count, hq_t.size());
  endtask

  initial begin
    int n_done;
    logic [31:0] tnow;
    tests = 0; fails = 0; mode = 0;
    bus.ev_valid = 1'b0; bus.ev_time = '0; bus.ev_pol = 1'b0;
    bus.start = 1'b0; bus.time_now = '0;
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset values.
    check("rst_drop", bus.ev_drop, 0);
    check("rst_pt", bus.pwl_time_point, 0);
    check("rst_sum", bus.sum_out, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.hist_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.ev_ready, 1);

    // Empty history: straight to drain, nothing issued.
    run_eval(32'd500, 1'b0, 0, 1'b0, 1'b0);
    check("empty_pt_unchanged", bus.pwl_time_point, 0);

    // Two events, opposite polarity.
    push_ev(32'd100, 1'b1);
    push_ev(32'd150, 1'b0);
    run_eval(32'd200, 1'b0, 0, 1'b0, 1'b0);
    check("two_ev_sum", bus.sum_out, 50);

    // Overflowing the history: only the 9th push drops.
    do_reset();
    for (int i = 0; i < 9; i++) push_ev(32'd1000 + 32'(i * 10), i[0] == 1'b0);
    check("full_count", bus.hist_count, N_TERMS);
    run_eval(32'd1200, 1'b0, 0, 1'b0, 1'b0);

    // Expiry truncates the history.
    do_reset();
    push_ev(32'd10, 1'b1);
    push_ev(32'd70000, 1'b1);
    push_ev(32'd70100, 1'b0);
    run_eval(32'd70200, 1'b0, 0, 1'b0, 1'b0);
    check("trunc_count", bus.hist_count, 2);

    // Push with start, plus start/push attempts while busy.
    run_eval(32'd70300, 1'b1, 32'd70250, 1'b1, 1'b1);

    // Reset in the middle of an evaluation: no done, history cleared.
    push_ev(32'd70400, 1'b1);
    bus.start = 1'b1; bus.time_now = 32'd70500;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hq_t.delete(); hq_p.delete();
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_count", bus.hist_count, 0);

    // Large same-sign results: saturate or wrap depending on the build.
    mode = 1;
    for (int i = 0; i < 8; i++) push_ev(32'(i), 1'b1);
    run_eval(32'd10, 1'b0, 0, 1'b0, 1'b0);
    check("sat_case_sum", bus.sum_out, SAT_CASE_EXP);
`ifdef PWL_SCHED_SAT_EN
    check("sat_case_flag", bus.sat_flag, 1);
`endif

    // Randomized history and evaluation times.
    mode = 2;
    do_reset();
    tnow = 32'h1000_0000;
    for (int it = 0; it < 14; it++) begin
      int np;
      np = $urandom_range(0, 4);
      tnow = tnow + 32'($urandom_range(0, 20000));
      for (int j = 0; j < np; j++)
        push_ev(tnow - 32'($urandom_range(0, 90000)), 1'($urandom_range(0, 1)));
      run_eval(tnow, 1'($urandom_range(0, 1)), tnow - 32'($urandom_range(0, 70000)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwl_filter_sched.md
Name: pwl_filter_sched

Overview:
- Time-multiplexes one PWL step-response evaluator (ROM plus linear-correction multiplier) across a history of past input-transition events.
- Stores up to N_TERMS event timestamps with polarity. On each start, it issues one time-since-event per cycle to the evaluator and accumulates the signed responses into one filter output sample.
- Sits between the transition detector (event producer) and the evaluator instance, on clk_sys.

Parameters:
- N_TERMS, 8, maximum stored events (power of 2).
- TIME_W, 32, absolute timestamp width (matches TIME_BITS).
- PT_W, 16, evaluator time_point width; covers dt in 0..2^PT_W-1.
- OUT_W, 18, evaluator output width, signed.
- ACC_W, 24, accumulator and sum_out width, signed; must be ≥ OUT_W+log2(N_TERMS).
- LAT, 2, evaluator latency in cycles from pwl_time_point to pwl_out.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous active-high reset
- ev_valid  in  1  event push request
- ev_ready  out  1  push accepted when high (combinational: state==IDLE)
- ev_time  in  TIME_W  event timestamp, unsigned
- ev_pol  in  1  1 = rising (+response), 0 = falling (−response)
- ev_drop  out  1  one-cycle pulse: oldest event discarded on push while full
- start  in  1  begin evaluation for time_now; ignored unless IDLE
- time_now  in  TIME_W  evaluation time, sampled on accepted start
- busy  out  1  high in all states except IDLE
- pwl_time_point  out  PT_W  registered time point to evaluator
- pwl_out  in  OUT_W  signed evaluator result
- sum_out  out  ACC_W  signed accumulated sample; held until next done
- done  out  1  one-cycle pulse; sum_out valid in the same cycle
- hist_count  out  log2(N_TERMS)+1  number of valid stored events

Behaviour:
- Reset values: ev_drop=0, pwl_time_point=0, sum_out=0, done=0, hist_count=0, all entries invalid, state IDLE. Reset mid-evaluation aborts it with no done pulse.
- History storage:
  - Shift register with the newest event at index 0.
  - A push (ev_valid&&ev_ready) shifts all entries up by one.
  - When hist_count==N_TERMS, the oldest entry is lost, ev_drop pulses for one cycle, and hist_count stays at N_TERMS.
- Push and start in the same IDLE cycle: the push is stored first. The evaluation then includes the new event.
- States and transitions:
  - IDLE → ISSUE on start.
  - ISSUE: one entry per cycle, idx=0..hist_count-1.
    - dt = time_now − ev_time, modulo 2^TIME_W.
    - dt < 2^PT_W: pwl_time_point<=dt[PT_W-1:0], tag valid, tag sign = ev_pol.
    - dt ≥ 2^PT_W (expired): tag invalid, set trunc=idx, go to DRAIN. Older entries are never issued.
    - Last entry issued → DRAIN.
  - hist_count==0 on start: IDLE → DRAIN directly.
  - DRAIN: LAT cycles, so results still in flight can return.
  - DONE: one cycle. done=1, sum_out=acc. If trunc is set, hist_count<=trunc and entries ≥ trunc are invalidated. Then go to IDLE.
- Tag pipeline: tags (valid, sign) delay by exactly LAT cycles, aligned with pwl_out.
- Accumulation: when the delayed tag is valid, acc += pwl_out for sign 1, acc −= pwl_out for sign 0. pwl_out is sign-extended to ACC_W. acc clears on start.
- Latency: with start at cycle t and k issued entries (k≥0), done is at cycle t+1+k+LAT. An expired slot still takes its ISSUE cycle.
- pwl_time_point holds its last value outside ISSUE.

Optional Feature:
- Macro: PWL_SCHED_SAT_EN.
- Defined: accumulation saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1], and sticky output sat_flag (1 bit) is set. sat_flag clears on start and on rst.
- Undefined: accumulation wraps two's-complement, and the sat_flag port is absent.

Decomposition:
- Package pwl_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), tag struct {valid, sign}, default width localparams tied to TIME_BITS and the evaluator widths.
- Sub-module pwl_event_hist: shift-register storage with push, drop and truncate. It exposes indexed read of time and pol plus the count.

Test Plan:
- Reset, then start with empty history → done at t+1+LAT (t+3 with LAT=2), sum_out=0, no pwl results consumed.
- Push ev_time=100 pol=1 and ev_time=150 pol=0; stub evaluator returns dt; start time_now=200 → time points 50 then 100; sum_out=100−50=50; done at t+5.
- Push 9 events into N_TERMS=8 → ev_drop pulses exactly once on the 9th push; hist_count=8; evaluation omits the first event.
- Events at 10, 70000, 70100; time_now=70200 → time points 100, 200, then the entry at 10 expires; done at t+6; hist_count=2 afterwards.
- Push and start in the same cycle: newest event issued first; ev_ready=0 while busy and pushes are held off; start during busy is ignored.
- With PWL_SCHED_SAT_EN and ACC_W=20: 8 events each returning +131071 → sum_out=524287, sat_flag=1. Without the macro: sum_out wraps to −8.
